// File: rtl/serial_pkg.sv
// Shared definitions for the serial word transmitter: FSM state encoding,
// default geometry and small elaboration-time helpers.
package serial_pkg;

  // Transmitter FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_e;

  // Default word width and inter-frame idle gap
  localparam int DEFAULT_NBITS      = 8;
  localparam int DEFAULT_GAP_CYCLES = 2;

  // Width of the gap down-counter; it only has to hold GAP_CYCLES-1
  function automatic int gap_cnt_width(input int gaps);
    if (gaps > 2) begin
      return $clog2(gaps);
    end else begin
      return 1;
    end
  endfunction

  // Value loaded into the gap counter so it reaches zero on the last gap cycle
  function automatic int gap_load_value(input int gaps);
    if (gaps > 0) begin
      return gaps - 1;
    end else begin
      return 0;
    end
  endfunction

endpackage

// File: rtl/tx_gap_counter.sv
// Loadable down-counter with a terminal-count flag, used to time the idle gap
// between frames. The counter saturates at zero; tc is high while it is zero.
module tx_gap_counter #(
  parameter int WIDTH = 2
) (
  input  logic             clk_2,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] count_r;

  // Load takes priority; otherwise count down while enabled, holding at zero
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (en && (count_r != CNT_ZERO)) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign tc = (count_r == CNT_ZERO);

endmodule

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter. A word captured on an accepted start is
// sent LSB-first, one bit per clk_2 cycle, followed by an optional idle gap and
// optional retransmission of the held word. Status outputs feed debug LEDs/LCD.
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int NBITS      = DEFAULT_NBITS,
  parameter int GAP_CYCLES = DEFAULT_GAP_CYCLES
) (
  input  logic                     clk_2,
  input  logic                     reset,
  input  logic [NBITS-1:0]         data_in,
  input  logic                     start,
  input  logic                     repeat_en,
  output logic                     serial_out,
  output logic                     bit_valid,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NBITS)-1:0] bit_idx,
  output logic [7:0]               frames_sent
);

  localparam int IDX_W = $clog2(NBITS);
  localparam int GAP_W = gap_cnt_width(GAP_CYCLES);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBITS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(gap_load_value(GAP_CYCLES));
  localparam logic [NBITS-1:0] WORD_ZERO = {NBITS{1'b0}};

  tx_state_e        state_r;
  // shift_reg_r holds the bits not yet driven onto serial_out; the bit on the
  // line lives in serial_out_r so the output stays a plain flop.
  logic [NBITS-1:0] shift_reg_r;
  logic [NBITS-1:0] hold_reg_r;
  logic             serial_out_r;
  logic             bit_valid_r;
  logic             busy_r;
  logic             done_r;
  logic [IDX_W-1:0] bit_idx_r;
  logic [7:0]       frames_sent_r;

  logic             last_bit_s;
  logic             gap_load_s;
  logic             gap_en_s;
  logic             gap_tc_s;

  // Gap timer controls: load on the final frame bit, count while in GAP
  always_comb begin
    last_bit_s = 1'b0;
    gap_load_s = 1'b0;
    gap_en_s   = 1'b0;
    if (state_r == SHIFT) begin
      last_bit_s = (bit_idx_r == LAST_IDX);
      gap_load_s = last_bit_s && HAS_GAP;
    end else if (state_r == GAP) begin
      gap_en_s = 1'b1;
    end else begin
      gap_en_s = 1'b0;
    end
  end

  tx_gap_counter #(
    .WIDTH (GAP_W)
  ) u_gap_counter (
    .clk_2    (clk_2),
    .reset    (reset),
    .load     (gap_load_s),
    .load_val (GAP_LOAD),
    .en       (gap_en_s),
    .tc       (gap_tc_s)
  );

  // Transmit FSM with registered outputs, word registers and frame counter
  always_ff @(posedge clk_2 or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      shift_reg_r   <= WORD_ZERO;
      hold_reg_r    <= WORD_ZERO;
      serial_out_r  <= 1'b0;
      bit_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      bit_idx_r     <= IDX_ZERO;
      frames_sent_r <= 8'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            // Bit 0 goes straight onto the line at the accepting edge
            hold_reg_r   <= data_in;
            shift_reg_r  <= data_in >> 1;
            serial_out_r <= data_in[0];
            bit_valid_r  <= 1'b1;
            busy_r       <= 1'b1;
            bit_idx_r    <= IDX_ZERO;
            state_r      <= SHIFT;
          end else begin
            serial_out_r <= 1'b0;
            bit_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            bit_idx_r    <= IDX_ZERO;
            state_r      <= IDLE;
          end
        end

        SHIFT: begin
          if (last_bit_s) begin
            done_r        <= 1'b1;
            frames_sent_r <= frames_sent_r + 8'd1;
            if (HAS_GAP) begin
              serial_out_r <= 1'b0;
              bit_valid_r  <= 1'b0;
              busy_r       <= 1'b1;
              bit_idx_r    <= IDX_ZERO;
              state_r      <= GAP;
            end else if (repeat_en) begin
              // Back-to-back retransmission: no idle bit between frames
              shift_reg_r  <= hold_reg_r >> 1;
              serial_out_r <= hold_reg_r[0];
              bit_valid_r  <= 1'b1;
              busy_r       <= 1'b1;
              bit_idx_r    <= IDX_ZERO;
              state_r      <= SHIFT;
            end else begin
              serial_out_r <= 1'b0;
              bit_valid_r  <= 1'b0;
              busy_r       <= 1'b0;
              bit_idx_r    <= IDX_ZERO;
              state_r      <= IDLE;
            end
          end else begin
            shift_reg_r  <= shift_reg_r >> 1;
            serial_out_r <= shift_reg_r[0];
            bit_valid_r  <= 1'b1;
            busy_r       <= 1'b1;
            bit_idx_r    <= bit_idx_r + IDX_ONE;
            state_r      <= SHIFT;
          end
        end

        GAP: begin
          if (gap_tc_s) begin
            if (repeat_en) begin
              shift_reg_r  <= hold_reg_r >> 1;
              serial_out_r <= hold_reg_r[0];
              bit_valid_r  <= 1'b1;
              busy_r       <= 1'b1;
              bit_idx_r    <= IDX_ZERO;
              state_r      <= SHIFT;
            end else begin
              serial_out_r <= 1'b0;
              bit_valid_r  <= 1'b0;
              busy_r       <= 1'b0;
              bit_idx_r    <= IDX_ZERO;
              state_r      <= IDLE;
            end
          end else begin
            serial_out_r <= 1'b0;
            bit_valid_r  <= 1'b0;
            busy_r       <= 1'b1;
            bit_idx_r    <= IDX_ZERO;
            state_r      <= GAP;
          end
        end

        default: begin
          // Unreachable encoding: return to a safe idle line
          serial_out_r <= 1'b0;
          bit_valid_r  <= 1'b0;
          busy_r       <= 1'b0;
          bit_idx_r    <= IDX_ZERO;
          state_r      <= IDLE;
        end
      endcase
    end
  end

  assign serial_out  = serial_out_r;
  assign bit_valid   = bit_valid_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign bit_idx     = bit_idx_r;
  assign frames_sent = frames_sent_r;

endmodule

// File: tb/tb_serial_word_tx.sv
// Scoreboard bench for serial_word_tx: one instance with a 2-cycle gap and one
// back-to-back (GAP_CYCLES=0) instance. Stimulus pushes expected bits and done
// pulses (tagged with the cycle they must appear in); monitors pop and compare.
module tb_serial_word_tx;

  logic       clk_2 = 1'b0;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_pass = 0;

  logic       reset_a = 1'b1, start_a = 1'b0, rep_a = 1'b0;
  logic [7:0] data_a = 8'h00;
  logic       so_a, bv_a, busy_a, done_a;
  logic [2:0] idx_a;
  logic [7:0] fs_a;

  logic       reset_b = 1'b1, start_b = 1'b0, rep_b = 1'b0;
  logic [7:0] data_b = 8'h00;
  logic       so_b, bv_b, busy_b, done_b;
  logic [2:0] idx_b;
  logic [7:0] fs_b;

  typedef struct { int cyc; logic b; logic [2:0] idx; } bit_exp_t;
  typedef struct { int cyc; logic [7:0] fs; } done_exp_t;

  bit_exp_t  qa[$], qb[$];
  done_exp_t da[$], db[$];

  always #5 clk_2 = ~clk_2;

  // Edge counter: at a negedge, cyc equals the number of rising edges so far
  always @(posedge clk_2) cyc <= cyc + 1;

  serial_word_tx #(.NBITS(8), .GAP_CYCLES(2)) dut_a (
    .clk_2(clk_2), .reset(reset_a), .data_in(data_a), .start(start_a),
    .repeat_en(rep_a), .serial_out(so_a), .bit_valid(bv_a), .busy(busy_a),
    .done(done_a), .bit_idx(idx_a), .frames_sent(fs_a)
  );

  serial_word_tx #(.NBITS(8), .GAP_CYCLES(0)) dut_b (
    .clk_2(clk_2), .reset(reset_b), .data_in(data_b), .start(start_b),
    .repeat_en(rep_b), .serial_out(so_b), .bit_valid(bv_b), .busy(busy_b),
    .done(done_b), .bit_idx(idx_b), .frames_sent(fs_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
  endtask

  task automatic push_bits_a(input int t, input logic [7:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      bit_exp_t e; e.cyc = t + k; e.b = w[k]; e.idx = 3'(k); qa.push_back(e);
    end
  endtask

  task automatic push_done_a(input int c, input logic [7:0] fs);
    done_exp_t d; d.cyc = c; d.fs = fs; da.push_back(d);
  endtask

  task automatic push_bits_b(input int t, input logic [7:0] w);
    for (int k = 0; k < 8; k++) begin
      bit_exp_t e; e.cyc = t + k; e.b = w[k]; e.idx = 3'(k); qb.push_back(e);
    end
  endtask

  task automatic push_done_b(input int c, input logic [7:0] fs);
    done_exp_t d; d.cyc = c; d.fs = fs; db.push_back(d);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_2);
  endtask

  // Monitor A: bit stream and done pulses against the scoreboard queues
  always @(negedge clk_2) begin : mon_a
    bit_exp_t  e;
    done_exp_t d;
    if (qa.size() > 0 && qa[0].cyc == cyc) begin
      e = qa.pop_front();
      chk("a_bit_valid", bv_a, 1);
      chk("a_serial_out", so_a, e.b);
      chk("a_bit_idx", idx_a, e.idx);
    end else begin
      chk("a_idle_bit_valid", bv_a, 0);
    end
    if (da.size() > 0 && da[0].cyc == cyc) begin
      d = da.pop_front();
      chk("a_done", done_a, 1);
      chk("a_frames_sent", fs_a, d.fs);
    end else begin
      chk("a_no_done", done_a, 0);
    end
  end

  // Monitor B: same checks for the back-to-back instance
  always @(negedge clk_2) begin : mon_b
    bit_exp_t  e;
    done_exp_t d;
    if (qb.size() > 0 && qb[0].cyc == cyc) begin
      e = qb.pop_front();
      chk("b_bit_valid", bv_b, 1);
      chk("b_serial_out", so_b, e.b);
      chk("b_bit_idx", idx_b, e.idx);
    end else begin
      chk("b_idle_bit_valid", bv_b, 0);
    end
    if (db.size() > 0 && db[0].cyc == cyc) begin
      d = db.pop_front();
      chk("b_done", done_b, 1);
      chk("b_frames_sent", fs_b, d.fs);
    end else begin
      chk("b_no_done", done_b, 0);
    end
  end

  initial begin : stim
    int t;
    // Reset state
    #1 reset_a = 1'b0; reset_b = 1'b0;
    #2;
    chk("rst_serial_out", so_a, 0);
    chk("rst_bit_valid", bv_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_bit_idx", idx_a, 0);
    chk("rst_frames", fs_a, 0);
    chk("rst_b_busy", busy_b, 0);
    chk("rst_b_frames", fs_b, 0);
    repeat (2) @(negedge clk_2);
    reset_a = 1'b1; reset_b = 1'b1;
    repeat (3) @(negedge clk_2);
    chk("idle_busy", busy_a, 0);

    // Single frame 0x0D, no repeat
    t = cyc + 1;
    data_a = 8'h0D; start_a = 1'b1;
    push_bits_a(t, 8'h0D, 8); push_done_a(t + 8, 8'd1);
    @(negedge clk_2); start_a = 1'b0; data_a = 8'h00;
    wait_until(t + 8);  chk("single_busy_gap0", busy_a, 1);
    wait_until(t + 9);  chk("single_busy_gap1", busy_a, 1);
    wait_until(t + 10); chk("single_busy_end", busy_a, 0);
    chk("single_frames", fs_a, 1);

    // Start held through the frame, data changed mid-frame
    repeat (2) @(negedge clk_2);
    t = cyc + 1;
    data_a = 8'h0D; start_a = 1'b1;
    push_bits_a(t, 8'h0D, 8); push_done_a(t + 8, 8'd2);
    wait_until(t + 3);  data_a = 8'hFF;
    wait_until(t + 10); chk("held_busy_end", busy_a, 0);
    start_a = 1'b0;
    repeat (4) @(negedge clk_2);
    chk("held_frames", fs_a, 2);

    // Repeat 0xA5 every 10 cycles, cleared during the third frame
    t = cyc + 1;
    data_a = 8'hA5; start_a = 1'b1; rep_a = 1'b1;
    for (int f = 0; f < 3; f++) begin
      push_bits_a(t + 10 * f, 8'hA5, 8);
      push_done_a(t + 10 * f + 8, 8'(3 + f));
    end
    @(negedge clk_2); start_a = 1'b0; data_a = 8'h00;
    wait_until(t + 23); rep_a = 1'b0;
    wait_until(t + 29); chk("rep_busy_gap", busy_a, 1);
    wait_until(t + 30); chk("rep_busy_end", busy_a, 0);
    chk("rep_frames", fs_a, 5);

    // Asynchronous reset in the middle of a frame
    repeat (2) @(negedge clk_2);
    t = cyc + 1;
    data_a = 8'h3C; start_a = 1'b1;
    push_bits_a(t, 8'h3C, 3);
    @(negedge clk_2); start_a = 1'b0;
    wait_until(t + 2);
    #2 reset_a = 1'b0;
    #1;
    chk("mid_rst_serial_out", so_a, 0);
    chk("mid_rst_bit_valid", bv_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_done", done_a, 0);
    chk("mid_rst_bit_idx", idx_a, 0);
    chk("mid_rst_frames", fs_a, 0);
    repeat (2) @(negedge clk_2);
    reset_a = 1'b1;
    repeat (4) @(negedge clk_2);
    chk("post_rst_busy", busy_a, 0);
    chk("post_rst_frames", fs_a, 0);

    // Recovery frame after reset
    t = cyc + 1;
    data_a = 8'h81; start_a = 1'b1;
    push_bits_a(t, 8'h81, 8); push_done_a(t + 8, 8'd1);
    @(negedge clk_2); start_a = 1'b0;
    wait_until(t + 12);

    // Back-to-back repeat on the GAP_CYCLES=0 instance, 256 frames to wrap
    t = cyc + 1;
    data_b = 8'h96; start_b = 1'b1; rep_b = 1'b1;
    for (int f = 0; f < 256; f++) begin
      push_bits_b(t + 8 * f, 8'h96);
      push_done_b(t + 8 * f + 8, 8'(f + 1));
    end
    @(negedge clk_2); start_b = 1'b0; data_b = 8'h00;
    wait_until(t + 2044); rep_b = 1'b0;
    wait_until(t + 2048);
    chk("wrap_busy_end", busy_b, 0);
    chk("wrap_frames", fs_b, 0);
    wait_until(t + 2052);

    chk("qa_drained", qa.size(), 0);
    chk("da_drained", da.size(), 0);
    chk("qb_drained", qb.size(), 0);
    chk("db_drained", db.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
